if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Purpose : instruction-fetch stage; drives the instruction-memory request and presents IF/ID registers to decode.
// Latency : one cycle from imem_ack to Instruction/PC_Out/Valid; one instruction per cycle with a zero-wait memory.
// Backpress: freeze holds IF/ID; a word that arrives while frozen parks in a one-entry skid buffer and fetching pauses.
module if_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_Out,
    output logic [31:0] Instruction,
    output logic        Valid
);

    // FETCH : request at PC; DRAIN : wait out a request orphaned by a branch;
    // STALL : a fetched word sits in the skid buffer while decode is frozen.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        STALL = 2'd2
    } state_t;

    // One IF/ID payload: the instruction word and the address after it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } ifid_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_addr;
    ifid_t       r_skid;
    ifid_t       r_ifid;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    ifid_t       w_fetched;

    // Modulo-2^32 increment: 0xFFFFFFFC wraps to 0.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_fetched  = '{instr: imem_rdata, pc_next: w_pc_plus4};

    // The request is gated by reset so nothing is issued while RST is low,
    // and it rises in the first cycle after release with PC = 0.
    assign imem_req  = RST && (r_state != STALL);

    // In DRAIN the address must stay on the orphaned request until it is
    // acknowledged, even though PC has already moved to the branch target.
    assign imem_addr = (r_state == FETCH) ? r_pc : r_req_addr;

    assign Instruction = r_ifid.instr;
    assign PC_Out      = r_ifid.pc_next;
    assign Valid       = r_valid;

    // Fetch FSM together with PC, request address, skid buffer and IF/ID registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= FETCH;
            r_pc       <= 32'd0;
            r_req_addr <= 32'd0;
            r_skid     <= '0;
            r_ifid     <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    // Remember what is on the bus in case a branch leaves it pending.
                    r_req_addr <= r_pc;
                    if (Branch_taken) begin
                        // Flush beats freeze; an ack this cycle is simply dropped.
                        r_ifid  <= '0;
                        r_valid <= 1'b0;
                        r_pc    <= Branch_Address;
                        r_state <= imem_ack ? FETCH : DRAIN;
                    end else if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (!freeze) begin
                            r_ifid  <= w_fetched;
                            r_valid <= 1'b1;
                        end else begin
                            // Decode still owns IF/ID: park the word and stop requesting.
                            r_skid  <= w_fetched;
                            r_state <= STALL;
                        end
                    end else if (!freeze) begin
                        // Decode consumed the current word and nothing new arrived.
                        r_valid <= 1'b0;
                    end
                end

                DRAIN: begin
                    // IF/ID is already flushed here; a further branch only retargets PC.
                    if (Branch_taken) begin
                        r_ifid <= '0;
                        r_pc   <= Branch_Address;
                    end
                    r_valid <= 1'b0;
                    // The stale response is discarded; resume at the (new) PC.
                    if (imem_ack) begin
                        r_state <= FETCH;
                    end
                end

                STALL: begin
                    if (Branch_taken) begin
                        // The parked word belongs to the wrong path: drop it.
                        r_ifid  <= '0;
                        r_valid <= 1'b0;
                        r_pc    <= Branch_Address;
                        r_state <= FETCH;
                    end else if (!freeze) begin
                        r_ifid  <= r_skid;
                        r_valid <= 1'b1;
                        r_state <= FETCH;
                    end
                end

                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        freeze = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] Branch_Address = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_Out;
    logic [31:0] Instruction;
    logic        Valid;

    if_stage dut (
        .CLK            (CLK),
        .RST            (RST),
        .freeze         (freeze),
        .Branch_taken   (Branch_taken),
        .Branch_Address (Branch_Address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .PC_Out         (PC_Out),
        .Instruction    (Instruction),
        .Valid          (Valid)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Memory model: word at address A is 0xE0000000 + A, ack after lat wait cycles.
    logic [3:0] lat = 4'd0;
    logic [3:0] wcnt;
    assign imem_ack   = imem_req && (wcnt == lat);
    assign imem_rdata = imem_ack ? (32'hE000_0000 + imem_addr) : 32'h0BAD_0BAD;

    always @(posedge CLK or negedge RST) begin
        if (!RST)                      wcnt <= 4'd0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 4'd1;
        else                           wcnt <= 4'd0;
    end

    // Hand-computed per-cycle table for the one-wait-cycle memory.
    logic        t2_valid [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t2_addr  [8] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_lin(input logic [31:0] a0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t        e;
            logic [31:0] a;
            a       = a0 + 32'(4 * i);
            e.instr = 32'hE000_0000 + a;
            e.pc    = a + 32'd4;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, Valid}, 32'd0);
        chk("rst_instr", Instruction, 32'd0);
        chk("rst_pcout", PC_Out, 32'd0);
        step();
        step();
        RST = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: pops one expectation per instruction decode consumes, and checks request stability.
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge CLK) begin
        if (!RST) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("req_hold", {31'd0, imem_req}, 32'd1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            if (Valid && !freeze) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got %h/%h, expected none", Instruction, PC_Out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("instr", Instruction, mon_e.instr);
                    chk("pc_out", PC_Out, mon_e.pc);
                end
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    initial begin
        // Zero-wait memory: back-to-back instructions from address 0.
        lat = 4'd0;
        push_lin(32'h0, 6);
        do_reset();
        @(negedge CLK);
        chk("req_after_rst", {31'd0, imem_req}, 32'd1);
        chk("addr_after_rst", imem_addr, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            @(negedge CLK);
            chk("zw_valid", {31'd0, Valid}, 32'd1);
            chk("zw_addr", imem_addr, 32'(4 * i));
        end
        drain();

        // One wait cycle per fetch: address held two cycles, bubbles between words.
        lat = 4'd1;
        push_lin(32'h0, 4);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("lat_valid", {31'd0, Valid}, {31'd0, t2_valid[i]});
            chk("lat_addr", imem_addr, t2_addr[i]);
            step();
        end
        drain();

        // Freeze for three cycles while the word at 0x8 arrives.
        lat = 4'd0;
        push_lin(32'h0, 5);
        do_reset();
        step();
        step();
        freeze = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge CLK);
            chk("frz_instr", Instruction, 32'hE000_0004);
            chk("frz_pcout", PC_Out, 32'h8);
            chk("frz_valid", {31'd0, Valid}, 32'd1);
            chk("frz_req", {31'd0, imem_req}, 32'd0);
        end
        step();
        freeze = 1'b0;
        drain();

        // Branch to 0x100 while the fetch of 0x10 waits on a two-wait-cycle memory.
        lat = 4'd2;
        push_lin(32'h0, 4);
        push_lin(32'h100, 2);
        do_reset();
        for (int t = 0; t < 40 && imem_addr != 32'h10; t++) step();
        chk("reach_0x10", imem_addr, 32'h10);
        Branch_taken   = 1'b1;
        Branch_Address = 32'h100;
        step();
        Branch_taken = 1'b0;
        @(negedge CLK);
        chk("drain_valid", {31'd0, Valid}, 32'd0);
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        step();
        step();
        @(negedge CLK);
        chk("branch_addr", imem_addr, 32'h100);
        drain();

        // Branch and freeze together while stalled: skid word must vanish.
        lat = 4'd0;
        push_lin(32'h200, 2);
        do_reset();
        step();
        freeze = 1'b1;
        step();
        Branch_taken   = 1'b1;
        Branch_Address = 32'h200;
        @(negedge CLK);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        step();
        Branch_taken = 1'b0;
        freeze       = 1'b0;
        @(negedge CLK);
        chk("stflush_valid", {31'd0, Valid}, 32'd0);
        chk("stflush_addr", imem_addr, 32'h200);
        drain();

        // Branch to 0xFFFFFFFC: PC wraps to 0.
        lat = 4'd0;
        push_lin(32'hFFFF_FFFC, 2);
        do_reset();
        Branch_taken   = 1'b1;
        Branch_Address = 32'hFFFF_FFFC;
        step();
        Branch_taken = 1'b0;
        @(negedge CLK);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge CLK);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_pcout", PC_Out, 32'h0);
        chk("wrap_instr", Instruction, 32'hDFFF_FFFC);
        chk("wrap_valid", {31'd0, Valid}, 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
